// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants, entry type and age-compare helper for the regfile write scheduler.
package regfile_sched_pkg;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int Q_DEPTH = 2;

    function automatic int tagWidth(input int numReq, input int qDepth);
        return $clog2(2 * numReq * qDepth);
    endfunction

    localparam int TAG_W = tagWidth(NUM_REQ, Q_DEPTH);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } wb_entry_t;

    // a is older than b when b sits less than half the tag space ahead of a
    function automatic logic older(input tag_t a, input tag_t b);
        tag_t diff;
        diff = b - a;
        return (diff != '0) && !diff[TAG_W-1];
    endfunction
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback request bus and register-file write port of the scheduler.
interface regfile_write_scheduler_if;
    import regfile_sched_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [2**ADDR_W-1:0]      busy_mask;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, busy_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, busy_mask
    );
endinterface

// File: rtl/regfile_write_scheduler_queue.sv
// Per-requester FIFO of tagged writeback entries; slot valids and addresses exported for busy tracking.
module sched_queue
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     pushEntry,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output wb_entry_t                     head,
    output logic [DEPTH-1:0]              entryValid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entryAddr
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]       wrPtr;
    logic [IDX_W-1:0]       rdPtr;
    wb_entry_t [DEPTH-1:0]  mem;

    function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = entryValid[wrPtr];
    assign empty = !entryValid[rdPtr];
    assign head  = mem[rdPtr];

    always_comb begin
        entryAddr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entryAddr[i] = mem[i].addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entryValid <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
        end else begin
            // push and pop never touch the same slot: push needs a free slot, pop a filled one
            if (push && !full) begin
                entryValid[wrPtr] <= 1'b1;
                wrPtr             <= nextPtr(wrPtr);
            end
            if (pop && !empty) begin
                entryValid[rdPtr] <= 1'b0;
                rdPtr             <= nextPtr(rdPtr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr] <= pushEntry;
        end
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates queued writeback sources onto the single regfile write port, oldest accept first.
module regfile_write_scheduler
    import regfile_sched_pkg::*;
(
    input logic                       clk,
    input logic                       rst,
    regfile_write_scheduler_if.slave  bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                qFull;
    logic [NUM_REQ-1:0]                qEmpty;
    logic [NUM_REQ-1:0]                qPush;
    logic [NUM_REQ-1:0]                qPop;
    wb_entry_t                         qHead      [NUM_REQ];
    wb_entry_t                         qPushEntry [NUM_REQ];
    logic [Q_DEPTH-1:0]                qValid     [NUM_REQ];
    logic [Q_DEPTH-1:0][ADDR_W-1:0]    qAddr      [NUM_REQ];

    tag_t               tagCnt;
    tag_t               tagNext;
    logic [SEL_W-1:0]   selIdx;
    logic               selFound;
    logic               wrEn;
    logic [ADDR_W-1:0]  wrAddr;
    logic [DATA_W-1:0]  wrData;
    logic [2**ADDR_W-1:0] busy;

    assign bus.req_ready = ~qFull & {NUM_REQ{~rst}};

    // Same-edge accepts get consecutive tags, lower index first; addr 0 is dropped untagged
    always_comb begin
        qPush   = '0;
        tagNext = tagCnt;
        for (int i = 0; i < NUM_REQ; i++) begin
            qPush[i] = bus.req_valid[i] && bus.req_ready[i]
                       && (bus.req_addr[i*ADDR_W +: ADDR_W] != '0);
            qPushEntry[i] = '{addr: bus.req_addr[i*ADDR_W +: ADDR_W],
                              data: bus.req_data[i*DATA_W +: DATA_W],
                              tag:  tagNext};
            if (qPush[i]) begin
                tagNext = tagNext + 1'b1;
            end
        end
    end

    always_comb begin
        selIdx   = '0;
        selFound = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!qEmpty[i] && (!selFound || older(qHead[i].tag, qHead[selIdx].tag))) begin
                selIdx   = SEL_W'(i);
                selFound = 1'b1;
            end
        end
        qPop         = '0;
        qPop[selIdx] = selFound;
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : gQueue
        sched_queue #(
            .DEPTH(Q_DEPTH)
        ) uQueue (
            .clk        (clk),
            .rst        (rst),
            .push       (qPush[g]),
            .pushEntry  (qPushEntry[g]),
            .pop        (qPop[g]),
            .full       (qFull[g]),
            .empty      (qEmpty[g]),
            .head       (qHead[g]),
            .entryValid (qValid[g]),
            .entryAddr  (qAddr[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagCnt <= '0;
            wrEn   <= 1'b0;
            wrAddr <= '0;
            wrData <= '0;
        end else begin
            tagCnt <= tagNext;
            wrEn   <= selFound;
            if (selFound) begin
                wrAddr <= qHead[selIdx].addr;
                wrData <= qHead[selIdx].data;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < Q_DEPTH; j++) begin
                if (qValid[i][j]) begin
                    busy[qAddr[i][j]] = 1'b1;
                end
            end
        end
        if (wrEn) begin
            busy[wrAddr] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    assign bus.wr_en     = wrEn;
    assign bus.wr_addr   = wrAddr;
    assign bus.wr_data   = wrData;
    assign bus.busy_mask = busy;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: accepted writes queue up in program order, a negedge monitor pops and compares.
module tb_regfile_write_scheduler;
    import regfile_sched_pkg::*;

    typedef struct {
        int                src;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    exp_t pending[$];
    logic [DATA_W-1:0] dutReg [2**ADDR_W];

    always #5 clk = ~clk;

    regfile_write_scheduler_if bus();

    regfile_write_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model's pending list is exactly what the DUT should still hold
    exp_t              monE;
    logic [31:0]       monBusy;
    int                monCnt0;
    int                monCnt1;
    always @(negedge clk) begin
        if (!rst) begin
            monBusy = '0;
            if (bus.wr_en) begin
                if (pending.size() == 0) begin
                    check("spurious_wr_en", bus.wr_en, 1'b0);
                end else begin
                    monE = pending.pop_front();
                    check("wr_addr", bus.wr_addr, monE.addr);
                    check("wr_data", bus.wr_data, monE.data);
                    monBusy[monE.addr] = 1'b1;
                    dutReg[bus.wr_addr] = bus.wr_data;
                end
            end
            monCnt0 = 0;
            monCnt1 = 0;
            foreach (pending[k]) begin
                monBusy[pending[k].addr] = 1'b1;
                if (pending[k].src == 0) monCnt0++;
                else monCnt1++;
            end
            check("busy_mask", bus.busy_mask, monBusy);
            check("req_ready", bus.req_ready, {monCnt1 < Q_DEPTH, monCnt0 < Q_DEPTH});
        end
    end

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        exp_t e;
        @(negedge clk);
        #2;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i] && bus.req_ready[i] && !rst) begin
                e.src  = i;
                e.addr = (i == 0) ? a0 : a1;
                e.data = (i == 0) ? d0 : d1;
                if (e.addr != '0) pending.push_back(e);
            end
        end
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pending.size() != 0 || bus.wr_en) && n < 100) begin
            idle();
            n++;
        end
        check("drain_empty", pending.size(), 0);
    endtask

    function automatic logic [4:0] randAddr(input bit allowZero);
        logic [4:0] a;
        a = 5'($urandom_range(allowZero ? 0 : 1, 31));
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  guard;
        int  src;
        bit  sawLow;
        logic [4:0]  a;
        logic [31:0] d;

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        foreach (dutReg[r]) dutReg[r] = '0;

        // reset state
        @(negedge clk);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_busy", bus.busy_mask, 32'h0);
        check("rst_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("release_ready", bus.req_ready, 2'b11);

        // single write latency and busy window
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
        idle();
        check("single_wr_en_k", bus.wr_en, 1'b0);
        check("single_busy_k", bus.busy_mask[5], 1'b1);
        idle();
        check("single_wr_en_k1", bus.wr_en, 1'b1);
        check("single_wr_addr", bus.wr_addr, 5'd5);
        check("single_wr_data", bus.wr_data, 32'hDEAD_BEEF);
        check("single_busy_k1", bus.busy_mask[5], 1'b1);
        idle();
        check("single_wr_en_k2", bus.wr_en, 1'b0);
        check("single_busy_k2", bus.busy_mask[5], 1'b0);
        drain();

        // same-edge conflict on reg 7
        drive(2'b11, 5'd7, 32'h1, 5'd7, 32'h2);
        drain();
        check("conflict_reg7", dutReg[7], 32'h2);

        // addr 0 is accepted and discarded
        drive(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
        check("addr0_ready", bus.req_ready[1], 1'b1);
        for (int c = 0; c < 3; c++) begin
            idle();
            check("addr0_no_wr", bus.wr_en, 1'b0);
            check("addr0_busy", bus.busy_mask, 32'h0);
        end

        // backpressure: src0 every cycle, src1 four cycles
        sawLow = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive({c < 4, 1'b1}, randAddr(0), $urandom, randAddr(0), $urandom);
            if (bus.req_ready != 2'b11) sawLow = 1'b1;
            if (c >= 2) check("bp_wr_each_cycle", bus.wr_en, 1'b1);
        end
        check("bp_ready_dropped", sawLow, 1'b1);
        drain();

        // tag wrap: 40 alternating single-source writes
        n = 0;
        guard = 0;
        while (n < 40 && guard < 200) begin
            src = n % 2;
            a = 5'((n % 31) + 1);
            d = $urandom;
            drive(src ? 2'b10 : 2'b01, a, d, a, d);
            if (bus.req_ready[src]) n++;
            guard++;
        end
        check("wrap_accepts", n, 40);
        drain();

        // random traffic including addr 0
        for (int c = 0; c < 150; c++) begin
            drive(2'($urandom_range(0, 3)), randAddr($urandom_range(0, 5) == 0), $urandom,
                  randAddr($urandom_range(0, 5) == 0), $urandom);
        end
        drain();

        // asynchronous reset mid-traffic
        for (int c = 0; c < 6; c++) begin
            drive(2'b11, randAddr(0), $urandom, randAddr(0), $urandom);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_wr_en", bus.wr_en, 1'b0);
        check("midrst_busy", bus.busy_mask, 32'h0);
        check("midrst_ready", bus.req_ready, 2'b00);
        pending.delete();
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_release_ready", bus.req_ready, 2'b11);
        for (int c = 0; c < 3; c++) begin
            idle();
            check("midrst_no_stale", bus.wr_en, 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
